branch_predictor: RTL and testbench

Dynamic branch predictor for the pipelined RV32 core. It is the parametrised successor to the combinational branch-select logic: it predicts direction and target at IF from a direct-mapped table of 2-bit saturating counters plus a tagged target buffer. At EX it trains on the resolved outcome and raises a redirect when the prediction was wrong. The block sits between the PC register (IF) and the branch-resolution logic (EX).

---
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped dynamic branch predictor for the RV32 pipeline.
// IF side: asynchronous lookup of a 2-bit saturating counter plus a tagged
// target buffer. EX side: trains on the resolved outcome and raises a redirect
// when the piped prediction was wrong.
// Optional feature macro: BP_STATS_EN adds br_cnt / miss_cnt statistics ports.
//
// ex_valid is a plain qualifier (no ready): when low, the EX inputs are
// ignored and no state changes; when high with is_br or is_jump set, the
// outcome is consumed on the rising edge that ends the cycle.
module branch_predictor #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_is_br,
  input  logic              ex_is_jump,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       br_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int ENTRIES = 1 << IDX_W;

  // Counter encoding: 00 strongly not-taken .. 11 strongly taken.
  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             train, ctr_we;
  logic [1:0]       ctr_old, ctr_nxt;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[ADDR_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[ADDR_W-1:IDX_W+2];

  // Instructions are word aligned; the byte-offset bits never select anything.
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // IF lookup: no bypass, a same-cycle EX write is seen next cycle.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + ADDR_W'(4);

  // EX resolution: an illegal br+jump combination counts as a jump.
  assign train       = ex_valid && (ex_is_br || ex_is_jump);
  assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ctr_old     = ctr_q[ex_idx];
  assign ctr_we      = train && (ex_hit || ex_taken);
  assign mispredict  = train && ((ex_taken != ex_pred_taken) ||
                                 (ex_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + ADDR_W'(4);

  // Next counter value: saturating step on a hit, fresh bias on allocation.
  always_comb begin
    ctr_nxt = ctr_old;
    if (ex_hit) begin
      if (ex_taken) begin
        if (ctr_old != 2'b11) ctr_nxt = ctr_old + 2'd1;
      end else begin
        if (ctr_old != 2'b00) ctr_nxt = ctr_old - 2'd1;
      end
    end else begin
      ctr_nxt = ex_is_jump ? 2'b11 : 2'b10;
    end
  end

  // Valid bits and counters: reset wins over any training write.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (ctr_we) begin
      valid_q[ex_idx] <= 1'b1;
      ctr_q[ex_idx]   <= ctr_nxt;
    end
  end

  // Tag and target: any taken outcome (hit or allocation) rewrites them.
  always_ff @(posedge clk) begin
    if (rstn && train && ex_taken) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= ex_target;
    end
  end

`ifdef BP_STATS_EN
  // Statistics: count training events and mispredicts, wrap at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (train)      br_cnt   <= br_cnt + 32'd1;
      if (mispredict) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scenarios plus randomized traffic, checked
// against a per-index table model (integer counters, full-PC tags).
// Build with +define+BP_STATS_EN to also exercise the statistics ports.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_br, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] br_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rstn(rstn), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_br(ex_is_br),
    .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .br_cnt(br_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // ---------------- reference model ----------------
  // 16 entries, index = (pc/4) mod 16, tag = pc/64, counter as an int 0..3.
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  bit          m_known = 0;
  longint      m_br = 0, m_miss = 0;

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_v[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / 64);
  endfunction

  function automatic bit m_pred_tk(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt(logic [31:0] pc);
    return m_pred_tk(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_event();
    return ex_valid && (ex_is_br || ex_is_jump);
  endfunction

  function automatic bit m_mispredict();
    if (!m_event()) return 0;
    if (ex_taken != ex_pred_taken) return 1;
    return ex_taken && (ex_target != ex_pred_target);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0;
      m_ctr[i] = 1;
    end
    m_br = 0;
    m_miss = 0;
    m_known = 1;
  endtask

  task automatic m_train();
    int i;
    if (!m_event()) return;
    m_br++;
    if (m_mispredict()) m_miss++;
    i = m_idx(ex_pc);
    if (m_hit(ex_pc)) begin
      m_ctr[i] = ex_taken ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                          : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
      if (ex_taken) m_tgt[i] = ex_target;
    end else if (ex_taken) begin
      m_v[i]   = 1;
      m_tag[i] = ex_pc / 64;
      m_tgt[i] = ex_target;
      m_ctr[i] = ex_is_jump ? 3 : 2;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [31:0] ipc, input bit ev, input bit br, input bit jmp,
                       input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                       input bit ptk, input logic [31:0] ptgt);
    if_pc = ipc; ex_valid = ev; ex_is_br = br; ex_is_jump = jmp;
    ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    check("mispredict", 32'(mispredict), 32'(m_mispredict()));
    check("redirect_pc", redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);
    if (m_known) begin
      check("pred_taken", 32'(pred_taken), 32'(m_pred_tk(if_pc)));
      check("pred_target", pred_target, m_pred_tgt(if_pc));
`ifdef BP_STATS_EN
      check("br_cnt", br_cnt, m_br[31:0]);
      check("miss_cnt", miss_cnt, m_miss[31:0]);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstn) m_reset();
    else m_train();
    @(negedge clk);
  endtask

  task automatic ex_op(input bit br, input bit jmp, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    apply(32'h0, 1, br, jmp, pc, tk, tgt, ptk, ptgt);
    tick();
  endtask

  // Idle EX; look up ipc and compare against fixed expected values.
  task automatic look(input logic [31:0] ipc, input bit exp_tk, input logic [31:0] exp_tgt);
    apply(ipc, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check("tp_pred_taken", 32'(pred_taken), 32'(exp_tk));
    check("tp_pred_target", pred_target, exp_tgt);
    tick();
  endtask

  task automatic reset_cycle();
    rstn = 1'b0;
    apply(32'h20, 1, 1, 0, 32'h20, 1, 32'h40, 0, 32'h24);
    tick();
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    apply(32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    reset_cycle();
    reset_cycle();

    // Reset state, including a training attempt dropped by reset.
    look(32'h10, 0, 32'h14);
    look(32'h20, 0, 32'h24);

    // First taken branch: mispredict, then predicted taken.
    apply(32'h20, 1, 1, 0, 32'h20, 1, 32'h40, 0, 32'h24);
    check("tp_first_mp", 32'(mispredict), 32'h1);
    check("tp_first_rd", redirect_pc, 32'h40);
    check("tp_no_bypass", 32'(pred_taken), 32'h0);
    tick();
    look(32'h20, 1, 32'h40);

    // Saturate, then walk down: 11 -> 10 still taken -> 01 not-taken.
    for (int k = 0; k < 3; k++) ex_op(1, 0, 32'h20, 1, 32'h40, 1, 32'h40);
    ex_op(1, 0, 32'h20, 0, 32'h40, 1, 32'h40);
    look(32'h20, 1, 32'h40);
    ex_op(1, 0, 32'h20, 0, 32'h40, 1, 32'h40);
    look(32'h20, 0, 32'h24);
    apply(32'h0, 1, 1, 0, 32'h20, 0, 32'h40, 1, 32'h40);
    check("tp_nt_mp", 32'(mispredict), 32'h1);
    check("tp_nt_rd", redirect_pc, 32'h24);
    tick();

    // Alias: 0x60 shares index 8 with 0x20 and replaces it.
    ex_op(1, 0, 32'h60, 1, 32'h100, 0, 32'h64);
    look(32'h20, 0, 32'h24);
    look(32'h60, 1, 32'h100);

    // jalr with a changing target.
    ex_op(0, 1, 32'h30, 1, 32'h80, 0, 32'h34);
    look(32'h30, 1, 32'h80);
    apply(32'h0, 1, 0, 1, 32'h30, 1, 32'h90, 1, 32'h80);
    check("tp_jalr_mp", 32'(mispredict), 32'h1);
    check("tp_jalr_rd", redirect_pc, 32'h90);
    tick();
    look(32'h30, 1, 32'h90);

    // Wrap of the +4 arithmetic at the top of the address space.
    look(32'hFFFF_FFFC, 0, 32'h0);

`ifdef BP_STATS_EN
    reset_cycle();
    for (int k = 0; k < 10; k++) ex_op(1, 0, 32'h200, 0, 32'h300, k < 3, 32'h300);
    apply(32'h0, 0, 1, 0, 32'h200, 1, 32'h300, 0, 32'h204);
    check("st_br10", br_cnt, 32'd10);
    check("st_miss3", miss_cnt, 32'd3);
    tick();
    apply(32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check("st_br_hold", br_cnt, 32'd10);
    check("st_miss_hold", miss_cnt, 32'd3);
    tick();
    reset_cycle();
    apply(32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check("st_br_rst", br_cnt, 32'd0);
    check("st_miss_rst", miss_cnt, 32'd0);
    tick();
`endif

    // Randomized traffic over a small PC window so hits and aliases are common.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc, tgt, ipc, ptgt;
      bit ev, br, jmp, tk, ptk;
      int kind;
      pc   = 32'($urandom_range(0, 63)) << 2;
      tgt  = 32'($urandom_range(0, 255)) << 2;
      kind = $urandom_range(0, 9);
      ev = 1; br = 1; jmp = 0; tk = $urandom_range(0, 1) == 1;
      case (kind)
        0: begin ev = 0; jmp = $urandom_range(0, 1) == 1; end
        1: br = 0;
        2: begin jmp = 1; tk = 1; end
        3, 4: begin br = 0; jmp = 1; tk = 1; end
        default: ;
      endcase
      if ($urandom_range(0, 9) < 7) begin
        ptk = m_pred_tk(pc); ptgt = m_pred_tgt(pc);
      end else begin
        ptk = $urandom_range(0, 1) == 1; ptgt = 32'($urandom_range(0, 255)) << 2;
      end
      ipc = ($urandom_range(0, 1) == 1) ? pc : 32'($urandom_range(0, 63)) << 2;
      rstn = ($urandom_range(0, 99) != 0);
      apply(ipc, ev, br, jmp, pc, tk, tgt, ptk, ptgt);
      tick();
    end
    rstn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
